mux_stage: RTL and testbench



---
 rtl/mux_stage_pkg.sv | 24 ++
 rtl/mux_stage_sel_mux.sv | 25 ++
 rtl/mux_stage.sv | 119 +++++++++++
 tb/tb_mux_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stage_pkg.sv
// Shared types and constants for the registered operand-select stage.
// Defaults match the PC/ALU/DataMem three-channel 2:1 configuration.
package mux_stage_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NCH_DEF   = 3;
  localparam int NIN_DEF   = 2;

  localparam int CH_PC   = 0;
  localparam int CH_ALU  = 1;
  localparam int CH_DMEM = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // A single-input channel still carries one select bit so the port never collapses to zero width.
  function automatic int sel_width(input int nin);
    return (nin > 1) ? $clog2(nin) : 1;
  endfunction

endpackage

// File: rtl/mux_stage_sel_mux.sv
// Combinational NIN:1 mux for one channel; latency 0, no backpressure.
// An unmatched select yields all-zero data and raises oor_o.
module sel_mux #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int SELW  = 1
) (
  input  logic [SELW-1:0]      sel_i,
  input  logic [NIN*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]     y_o,
  output logic                 oor_o
);

  always_comb begin
    y_o   = '0;
    oor_o = 1'b1;
    for (int i = 0; i < NIN; i++) begin
      if (sel_i == SELW'(i)) begin
        y_o   = data_i[i*WIDTH +: WIDTH];
        oor_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_stage.sv
// Per-channel operand select captured into a two-entry skid buffer; output valid one cycle after accept.
// Absorbs two sets when out_ready is low; in_ready is registered and has no path from out_ready.
module mux_stage
  import mux_stage_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  NCH   = NCH_DEF,
  parameter int  NIN   = NIN_DEF,
  localparam int SELW  = sel_width(NIN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*SELW-1:0]      sel,
  input  logic [NCH*NIN*WIDTH-1:0] data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*WIDTH-1:0]     out_data,
  input  logic                     err_clr,
  output logic [NCH-1:0]           sel_err
);

  logic [NCH*WIDTH-1:0] cap_dat;
  logic [NCH-1:0]       cap_oor;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sel_mux #(
      .WIDTH (WIDTH),
      .NIN   (NIN),
      .SELW  (SELW)
    ) u_sel_mux (
      .sel_i  (sel[c*SELW +: SELW]),
      .data_i (data[c*NIN*WIDTH +: NIN*WIDTH]),
      .y_o    (cap_dat[c*WIDTH +: WIDTH]),
      .oor_o  (cap_oor[c])
    );
  end

  state_e               state_q, state_d;
  logic [NCH*WIDTH-1:0] main_q, main_d;
  logic [NCH*WIDTH-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic [NCH-1:0]       sel_err_q, sel_err_d;

  logic accept;
  logic xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign sel_err   = sel_err_q;

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // MAIN keeps its contents so out_data holds while out_valid is low.
      state_d = EMPTY;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = cap_dat;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            main_d = cap_dat;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = cap_dat;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign in_ready_d = (state_d != TWO);

  // A fresh error on a channel outranks err_clr for that bit.
  assign sel_err_d = (err_clr ? '0 : sel_err_q) | ((accept && !flush) ? cap_oor : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      sel_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_mux_stage.sv
// Randomized bench for mux_stage: NIN=2 and NIN=3 instances share control and are
// checked against a queue-based reference model.
module tb_mux_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;
  logic err_clr = 1'b0;

  logic [2:0]  sel2 = '0;
  logic [47:0] data2 = '0;
  logic        in_ready2, out_valid2;
  logic [23:0] out2;
  logic [2:0]  err2;

  logic [5:0]  sel3 = '0;
  logic [71:0] data3 = '0;
  logic        in_ready3, out_valid3;
  logic [23:0] out3;
  logic [2:0]  err3;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] q2[$];
  logic [23:0] q3[$];
  logic [23:0] l2 = '0;
  logic [23:0] l3 = '0;
  logic [2:0]  e2 = '0;
  logic [2:0]  e3 = '0;
  bit          m_rdy = 1'b1;

  always #5 clk = ~clk;

  mux_stage #(.WIDTH(8), .NCH(3), .NIN(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .sel(sel2), .data(data2), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out2), .err_clr(err_clr), .sel_err(err2)
  );

  mux_stage #(.WIDTH(8), .NCH(3), .NIN(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .sel(sel3), .data(data3), .flush(flush), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out3), .err_clr(err_clr), .sel_err(err3)
  );

  function automatic logic [23:0] pick2(input logic [2:0] s, input logic [47:0] d);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = d[(c*2 + int'(s[c]))*8 +: 8];
    return r;
  endfunction

  function automatic logic [23:0] pick3(input logic [5:0] s, input logic [71:0] d);
    logic [23:0] r;
    int k;
    for (int c = 0; c < 3; c++) begin
      k = int'(s[c*2 +: 2]);
      if (k >= 3) r[c*8 +: 8] = 8'h00;
      else        r[c*8 +: 8] = d[(c*3 + k)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [2:0] bad3(input logic [5:0] s);
    logic [2:0] r;
    for (int c = 0; c < 3; c++) r[c] = (int'(s[c*2 +: 2]) >= 3);
    return r;
  endfunction

  // Advance the reference model by one clock, then move to 1ns after the edge.
  task automatic step();
    bit acc, xf;
    acc = in_valid && m_rdy;
    xf  = out_ready && (q2.size() > 0);
    if (flush) begin
      q2.delete();
      q3.delete();
    end else begin
      if (xf) begin
        void'(q2.pop_front());
        void'(q3.pop_front());
      end
      if (acc) begin
        q2.push_back(pick2(sel2, data2));
        q3.push_back(pick3(sel3, data3));
      end
    end
    if (err_clr) begin
      e2 = '0;
      e3 = '0;
    end
    if (acc && !flush) e3 = e3 | bad3(sel3);
    m_rdy = (q2.size() < 2);
    if (q2.size() > 0) begin
      l2 = q2[0];
      l3 = q3[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    sel2  = 3'($urandom());
    sel3  = 6'($urandom());
    data2 = {16'($urandom()), $urandom()};
    data3 = {8'($urandom()), $urandom(), $urandom()};
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    vectors++;
    if ({out_valid2, in_ready2, out2, err2} !== {1'b0, 1'b1, 24'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_state2: got v=%b r=%b d=%h e=%b, want v=0 r=1 d=000000 e=000",
               out_valid2, in_ready2, out2, err2);
    end
    vectors++;
    if ({out_valid3, in_ready3, out3, err3} !== {1'b0, 1'b1, 24'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_state3: got v=%b r=%b d=%h e=%b, want v=0 r=1 d=000000 e=000",
               out_valid3, in_ready3, out3, err3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    in_valid = 1'b1; out_ready = 1'b1;
    sel2 = 3'b101; data2 = 48'h665544332211; sel3 = '0;
    step();
    vectors++;
    if (out_valid2 !== 1'b1 || out2 !== 24'h663322) begin
      miscompares++;
      $display("FAIL basic_select: got v=%b d=%h, want v=1 d=663322", out_valid2, out2);
    end
    for (int i = 0; i < 6; i++) begin
      randomize_inputs();
      sel3 = {1'b0, sel3[4], 1'b0, sel3[2], 1'b0, sel3[0]};
      step();
      vectors++;
      if ({out_valid2, in_ready2, out2} !== {1'b1, 1'b1, l2} || out3 !== l3) begin
        miscompares++;
        $display("FAIL sustained[%0d]: got v=%b r=%b d2=%h d3=%h, want v=1 r=1 d2=%h d3=%h",
                 i, out_valid2, in_ready2, out2, out3, l2, l3);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [23:0] a, b;
    in_valid = 1'b0; out_ready = 1'b1; step();
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); sel3 = '0; a = pick2(sel2, data2);
    step();
    vectors++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b1 || out2 !== a) begin
      miscompares++;
      $display("FAIL b2b_first: got r=%b v=%b d=%h, want r=1 v=1 d=%h", in_ready2, out_valid2, out2, a);
    end
    randomize_inputs(); sel3 = '0; b = pick2(sel2, data2);
    step();
    vectors++;
    if (in_ready2 !== 1'b0 || out2 !== a) begin
      miscompares++;
      $display("FAIL b2b_full: got r=%b d=%h, want r=0 d=%h", in_ready2, out2, a);
    end
    randomize_inputs(); sel3 = '0;
    step();
    vectors++;
    if (in_ready2 !== 1'b0 || out2 !== a || out_valid2 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_third_held: got r=%b v=%b d=%h, want r=0 v=1 d=%h", in_ready2, out_valid2, out2, a);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    vectors++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b1 || out2 !== b) begin
      miscompares++;
      $display("FAIL b2b_drain1: got r=%b v=%b d=%h, want r=1 v=1 d=%h", in_ready2, out_valid2, out2, b);
    end
    step();
    vectors++;
    if (out_valid2 !== 1'b0 || out2 !== b) begin
      miscompares++;
      $display("FAIL b2b_drain2: got v=%b d=%h, want v=0 d=%h (held)", out_valid2, out2, b);
    end
  endtask

  task automatic test_sel_err();
    in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
    sel3 = 6'b00_11_00; data3 = {8'($urandom()), $urandom(), $urandom()};
    step();
    vectors++;
    if (out3[15:8] !== 8'h00 || err3 !== 3'b010 || out3 !== pick3(sel3, data3)) begin
      miscompares++;
      $display("FAIL sel_err_set: got d=%h e=%b, want ch1=00 d=%h e=010", out3, err3, pick3(sel3, data3));
    end
    err_clr = 1'b1;
    step();
    vectors++;
    if (err3 !== 3'b010) begin
      miscompares++;
      $display("FAIL sel_err_clr_vs_new: got e=%b, want e=010", err3);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (err3 !== 3'b000 || err2 !== 3'b000) begin
      miscompares++;
      $display("FAIL sel_err_clear: got e3=%b e2=%b, want 000/000", err3, err2);
    end
    err_clr = 1'b0; sel3 = '0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); step();
    randomize_inputs(); step();
    vectors++;
    if (in_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_setup: got r=%b, want r=0", in_ready2);
    end
    flush = 1'b1; randomize_inputs();
    step();
    vectors++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || out_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: got v=%b r=%b v3=%b, want v=0 r=1 v3=0", out_valid2, in_ready2, out_valid3);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid2 !== 1'b0 || out2 !== l2) begin
        miscompares++;
        $display("FAIL flush_quiet[%0d]: got v=%b d=%h, want v=0 d=%h", i, out_valid2, out2, l2);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      randomize_inputs();
      step();
      vectors++;
      if ({out_valid2, in_ready2, out2, err2} !== {q2.size() > 0, m_rdy, l2, e2}) begin
        miscompares++;
        $display("FAIL random2[%0d]: got v=%b r=%b d=%h e=%b, want v=%b r=%b d=%h e=%b",
                 i, out_valid2, in_ready2, out2, err2, q2.size() > 0, m_rdy, l2, e2);
      end
      vectors++;
      if ({out_valid3, in_ready3, out3, err3} !== {q3.size() > 0, m_rdy, l3, e3}) begin
        miscompares++;
        $display("FAIL random3[%0d]: got v=%b r=%b d=%h e=%b, want v=%b r=%b d=%h e=%b",
                 i, out_valid3, in_ready3, out3, err3, q3.size() > 0, m_rdy, l3, e3);
      end
    end
    flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b0; out_ready = 1'b1; step(); step();
    out_ready = 1'b0; in_valid = 1'b1;
    randomize_inputs(); sel3 = 6'b00_11_00; step();
    randomize_inputs(); step();
    #2 reset = 1'b1;
    #1;
    q2.delete(); q3.delete();
    l2 = '0; l3 = '0; e2 = '0; e3 = '0; m_rdy = 1'b1;
    vectors++;
    if ({out_valid2, in_ready2, out2} !== {1'b0, 1'b1, 24'h0} ||
        {out_valid3, in_ready3, out3, err3} !== {1'b0, 1'b1, 24'h0, 3'b000}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b r=%b d=%h v3=%b r3=%b d3=%h e3=%b, want 0/1/0 and 0/1/0/000",
               out_valid2, in_ready2, out2, out_valid3, in_ready3, out3, err3);
    end
    @(negedge clk);
    reset = 1'b0;
    randomize_inputs(); sel3 = '0; out_ready = 1'b0;
    step();
    vectors++;
    if ({out_valid2, in_ready2, out2} !== {1'b1, 1'b1, l2} || out3 !== l3) begin
      miscompares++;
      $display("FAIL post_reset_accept: got v=%b r=%b d=%h d3=%h, want v=1 r=1 d=%h d3=%h",
               out_valid2, in_ready2, out2, out3, l2, l3);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sel_err();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
